pltrst_seq_ctrl: RTL and testbench

// - Platform reset sequencer. Sits behind the system reset request logic and drives the GLP and IO reset pins.
// - Releases rst_gmt_n/gmt_lreset_n and then rst_io_n[] in a timed, staggered order once power is steady.
// - Re-asserts all resets on a system reset request, bracketed by forcepr_mask (no PROCHOT around RESET_N edges).
// - Asserts all resets immediately on a power fault or on loss of st_steady_pwrok.

---
 rtl/pltrst_seq_pkg.sv | 26 ++
 rtl/us_delay_cnt.sv | 37 +++
 rtl/pltrst_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pltrst_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pltrst_seq_pkg.sv
// rtl/pltrst_seq_pkg.sv - platform reset sequencer state encodings and width helper
package pltrst_seq_pkg;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] REL  = 3'd2;
  localparam logic [2:0] MASK = 3'd3;
  localparam logic [2:0] RUN  = 3'd4;
  localparam logic [2:0] ASRT = 3'd5;
  localparam logic [2:0] HOLD = 3'd6;

  // Bits needed to hold value itself (not value-1), minimum 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/us_delay_cnt.sv
// rtl/us_delay_cnt.sv - reloadable microsecond down-counter with expiry flag
module us_delay_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         t1us_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over the tick, so a t1us on the loading edge is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (t1us_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stays high once expired until reloaded; HOLD relies on that level.
  assign expired_o = (cnt_q == '0) | (t1us_i & (cnt_q == W'(1)));

endmodule

// File: rtl/pltrst_seq_ctrl.sv
// rtl/pltrst_seq_ctrl.sv - platform reset sequencer driving GLP and IO reset pins
module pltrst_seq_ctrl
  import pltrst_seq_pkg::*;
#(
  parameter int NUM_IO        = 1,
  parameter int PRE_DLY_US    = 100,
  parameter int STAGGER_US    = 10,
  parameter int ASSERT_DLY_US = 3,
  parameter int MIN_ASSERT_US = 20,
  parameter int MASK_DLY_US   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              t1us,
  input  logic              st_steady_pwrok,
  input  logic              rt_critical_fail_store,
  input  logic              pal_sys_reset,
  input  logic              rst_pcie_cpu_n,
  output logic              rst_gmt_n,
  output logic              gmt_lreset_n,
  output logic [NUM_IO-1:0] rst_io_n,
  output logic              forcepr_mask,
  output logic              seq_done,
  output logic [2:0]        seq_state
);

  localparam int MAX_A   = (PRE_DLY_US > STAGGER_US) ? PRE_DLY_US : STAGGER_US;
  localparam int MAX_B   = (ASSERT_DLY_US > MIN_ASSERT_US) ? ASSERT_DLY_US : MIN_ASSERT_US;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_DLY = (MAX_C > MASK_DLY_US) ? MAX_C : MASK_DLY_US;
  localparam int CNT_W   = clogb2(MAX_DLY);
  localparam int IDX_W   = clogb2(NUM_IO);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_IO-1:0] released_q, released_d;
  logic [NUM_IO-1:0] io_q, io_d;
  logic              gmt_q, gmt_d;
  logic              mask_q, mask_d;
  logic              done_q, done_d;
  logic              fault;
  logic              rel_step;
  logic              dly_load;
  logic              dly_expired;
  logic [CNT_W-1:0]  dly_val;

  assign fault = rt_critical_fail_store | ~st_steady_pwrok;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    released_d = released_q;
    gmt_d      = gmt_q;
    mask_d     = mask_q;
    done_d     = done_q;
    rel_step   = 1'b0;
    if (fault) begin
      state_d    = OFF;
      idx_d      = '0;
      released_d = '0;
      gmt_d      = 1'b0;
      mask_d     = 1'b1;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        OFF: state_d = PRE;
        PRE: begin
          if (pal_sys_reset) begin
            state_d = ASRT;
            mask_d  = 1'b1;
          end else if (dly_expired) begin
            gmt_d   = 1'b1;
            idx_d   = '0;
            state_d = REL;
          end
        end
        REL: begin
          if (pal_sys_reset) begin
            state_d = ASRT;
            mask_d  = 1'b1;
          end else if (dly_expired) begin
            for (int i = 0; i < NUM_IO; i++) begin
              if (idx_q == IDX_W'(i)) released_d[i] = 1'b1;
            end
            if (idx_q == IDX_W'(NUM_IO - 1)) begin
              state_d = MASK;
            end else begin
              idx_d    = idx_q + IDX_W'(1);
              rel_step = 1'b1;
            end
          end
        end
        MASK: begin
          if (pal_sys_reset) begin
            state_d = ASRT;
            mask_d  = 1'b1;
          end else if (dly_expired) begin
            mask_d  = 1'b0;
            done_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (pal_sys_reset) begin
            state_d = ASRT;
            mask_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        ASRT: begin
          if (dly_expired) begin
            gmt_d      = 1'b0;
            released_d = '0;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (dly_expired && !pal_sys_reset) state_d = PRE;
        end
        default: begin
          state_d    = OFF;
          idx_d      = '0;
          released_d = '0;
          gmt_d      = 1'b0;
          mask_d     = 1'b1;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  // The shared delay counter is reloaded on every state change and per IO step.
  assign dly_load = (state_d != state_q) | rel_step;

  always_comb begin
    dly_val = '0;
    case (state_d)
      PRE:     dly_val = CNT_W'(PRE_DLY_US);
      REL:     dly_val = CNT_W'(STAGGER_US);
      MASK:    dly_val = CNT_W'(MASK_DLY_US);
      ASRT:    dly_val = CNT_W'(ASSERT_DLY_US);
      HOLD:    dly_val = CNT_W'(MIN_ASSERT_US);
      default: dly_val = '0;
    endcase
  end

  us_delay_cnt #(
    .W (CNT_W)
  ) u_dly (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (dly_load),
    .value_i   (dly_val),
    .t1us_i    (t1us),
    .expired_o (dly_expired)
  );

  assign io_d = released_d & {NUM_IO{rst_pcie_cpu_n}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OFF;
      idx_q      <= '0;
      released_q <= '0;
      io_q       <= '0;
      gmt_q      <= 1'b0;
      mask_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      released_q <= released_d;
      io_q       <= io_d;
      gmt_q      <= gmt_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
    end
  end

  assign rst_gmt_n    = gmt_q;
  assign gmt_lreset_n = gmt_q;
  assign rst_io_n     = io_q;
  assign forcepr_mask = mask_q;
  assign seq_done     = done_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_pltrst_seq_ctrl.sv
// tb/tb_pltrst_seq_ctrl.sv - directed vector bench for the platform reset sequencer
module tb_pltrst_seq_ctrl;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_REL  = 3'd2;
  localparam logic [2:0] S_MASK = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ASRT = 3'd5;
  localparam logic [2:0] S_HOLD = 3'd6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       t1us;
  logic       st_steady_pwrok;
  logic       rt_critical_fail_store;
  logic       pal_sys_reset;
  logic       rst_pcie_cpu_n;
  logic       rst_gmt_n;
  logic       gmt_lreset_n;
  logic [1:0] rst_io_n;
  logic       forcepr_mask;
  logic       seq_done;
  logic [2:0] seq_state;

  typedef struct {
    logic       pwrok;
    logic       fail;
    logic       req;
    logic       pcie;
    int         n_us;
    int         n_clk;
    logic [2:0] st;
    logic       gmt;
    logic [1:0] io;
    logic       mask;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   us_cnt;

  always #5 clk = ~clk;

  pltrst_seq_ctrl #(
    .NUM_IO        (2),
    .PRE_DLY_US    (100),
    .STAGGER_US    (10),
    .ASSERT_DLY_US (3),
    .MIN_ASSERT_US (20),
    .MASK_DLY_US   (3)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .t1us                   (t1us),
    .st_steady_pwrok        (st_steady_pwrok),
    .rt_critical_fail_store (rt_critical_fail_store),
    .pal_sys_reset          (pal_sys_reset),
    .rst_pcie_cpu_n         (rst_pcie_cpu_n),
    .rst_gmt_n              (rst_gmt_n),
    .gmt_lreset_n           (gmt_lreset_n),
    .rst_io_n               (rst_io_n),
    .forcepr_mask           (forcepr_mask),
    .seq_done               (seq_done),
    .seq_state              (seq_state)
  );

  // t1us is bench-driven: one pulse every 10 clocks keeps runs short but exact.
  task automatic cyc(input logic pulse);
    t1us = pulse;
    @(posedge clk);
    #1;
    t1us = 1'b0;
  endtask

  task automatic run_us(input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 9; j++) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic add(input logic pw, input logic fl, input logic rq, input logic pc,
                     input int nu, input int nc, input logic [2:0] st, input logic g,
                     input logic [1:0] io, input logic m, input logic d);
    vec_t v;
    v.pwrok = pw; v.fail = fl; v.req = rq; v.pcie = pc;
    v.n_us = nu; v.n_clk = nc;
    v.st = st; v.gmt = g; v.io = io; v.mask = m; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic g,
                       input logic [1:0] io, input logic m, input logic d);
    n_vec++;
    if ({seq_state, rst_gmt_n, gmt_lreset_n, rst_io_n, forcepr_mask, seq_done} !==
        {st, g, g, io, m, d}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d gmt=%b lrst=%b io=%b mask=%b done=%b, want state=%0d gmt=%b lrst=%b io=%b mask=%b done=%b",
               name, seq_state, rst_gmt_n, gmt_lreset_n, rst_io_n, forcepr_mask, seq_done,
               st, g, g, io, m, d);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //   pw    fail  req   pcie  us   clk  state   gmt   io     mask  done
    add(1'b0, 1'b0, 1'b0, 1'b1,   0,  3, S_OFF,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   0,  1, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  99,  0, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_REL,  1'b1, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   9,  0, S_REL,  1'b1, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_REL,  1'b1, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   9,  0, S_REL,  1'b1, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_MASK, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   2,  0, S_MASK, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_RUN,  1'b1, 2'b11, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1,   5,  0, S_RUN,  1'b1, 2'b11, 1'b0, 1'b1);
    // request in RUN, then full re-release
    add(1'b1, 1'b0, 1'b1, 1'b1,   0,  1, S_ASRT, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   2,  0, S_ASRT, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  19,  0, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 100,  0, S_REL,  1'b1, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  10,  0, S_REL,  1'b1, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  10,  0, S_MASK, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   3,  0, S_RUN,  1'b1, 2'b11, 1'b0, 1'b1);
    // BIOS PCIe reset gates only the IO pins
    add(1'b1, 1'b0, 1'b0, 1'b0,   0,  1, S_RUN,  1'b1, 2'b00, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0,   5,  0, S_RUN,  1'b1, 2'b00, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1,   0,  1, S_RUN,  1'b1, 2'b11, 1'b0, 1'b1);
    // pwrok loss and request on the same clock: fault wins
    add(1'b0, 1'b0, 1'b1, 1'b1,   0,  1, S_OFF,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1,   3,  0, S_OFF,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   0,  1, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    // fault mid-REL
    add(1'b1, 1'b0, 1'b0, 1'b1, 100,  0, S_REL,  1'b1, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  10,  0, S_REL,  1'b1, 2'b01, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1,   0,  1, S_OFF,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 150,  0, S_OFF,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   0,  1, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 123,  0, S_RUN,  1'b1, 2'b11, 1'b0, 1'b1);
    // request held for 50us
    add(1'b1, 1'b0, 1'b1, 1'b1,   0,  1, S_ASRT, 1'b1, 2'b11, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1,   3,  0, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1,  47,  0, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   0,  1, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  99,  0, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   1,  0, S_REL,  1'b1, 2'b00, 1'b1, 1'b0);
    // request in REL keeps GLP released until ASRT expires; request in HOLD absorbed
    add(1'b1, 1'b0, 1'b1, 1'b1,   0,  1, S_ASRT, 1'b1, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,   3,  0, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1,   0,  1, S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  20,  0, S_PRE,  1'b0, 2'b00, 1'b1, 1'b0);

    reset_n                = 1'b0;
    t1us                   = 1'b0;
    st_steady_pwrok        = 1'b0;
    rt_critical_fail_store = 1'b0;
    pal_sys_reset          = 1'b0;
    rst_pcie_cpu_n         = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    check("reset", S_OFF, 1'b0, 2'b00, 1'b1, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      st_steady_pwrok        = vecs[i].pwrok;
      rt_critical_fail_store = vecs[i].fail;
      pal_sys_reset          = vecs[i].req;
      rst_pcie_cpu_n         = vecs[i].pcie;
      run_us(vecs[i].n_us);
      for (int c = 0; c < vecs[i].n_clk; c++) cyc(1'b0);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].gmt, vecs[i].io, vecs[i].mask, vecs[i].done);
    end

    // bounded wait for seq_done: PRE 100 + 2*STAGGER 10 + MASK 3 = 123us
    us_cnt = 0;
    while (!seq_done && us_cnt < 200) begin
      run_us(1);
      us_cnt++;
    end
    n_vec++;
    if (us_cnt != 123) begin
      n_bad++;
      $display("FAIL seq_done_latency: got %0d us, want 123 us", us_cnt);
    end
    check("run_again", S_RUN, 1'b1, 2'b11, 1'b0, 1'b1);

    // single-clock PCIe reset glitch follows with one clock latency
    rst_pcie_cpu_n = 1'b0;
    cyc(1'b0);
    check("pcie_glitch_low", S_RUN, 1'b1, 2'b00, 1'b0, 1'b1);
    rst_pcie_cpu_n = 1'b1;
    cyc(1'b0);
    check("pcie_glitch_high", S_RUN, 1'b1, 2'b11, 1'b0, 1'b1);

    // a t1us coinciding with the entry edge must not count toward ASRT
    pal_sys_reset = 1'b1;
    cyc(1'b1);
    check("entry_tick_asrt", S_ASRT, 1'b1, 2'b11, 1'b1, 1'b0);
    pal_sys_reset = 1'b0;
    run_us(2);
    check("entry_tick_ignored", S_ASRT, 1'b1, 2'b11, 1'b1, 1'b0);
    run_us(1);
    check("entry_tick_hold", S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
